// File: rtl/fir_filter_tdm_multichannel.sv
// Time-multiplexed multi-channel FIR: one MAC pipeline serves CHANNELS histories with shared coefficients.
// Define FIR_SATURATE_EN to clamp the shifted accumulator instead of wrapping it to DATA_WIDTH bits.
module fir_filter_tdm_multichannel #(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 18,
  parameter int FIR_DEPTH  = 16,
  parameter int CHANNELS   = 2,
  parameter int OUT_SHIFT  = 17,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TAP_W     = $clog2(FIR_DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] iv_din,
  input  logic        [CH_W-1:0]       iv_din_ch,
  input  logic                         i_din_valid,
  output logic                         o_din_ready,
  output logic signed [DATA_WIDTH-1:0] ov_dout,
  output logic        [CH_W-1:0]       ov_dout_ch,
  output logic                         o_dout_valid,
  input  logic                         i_dout_ready,
  input  logic                         i_coef_we,
  input  logic        [TAP_W-1:0]      iv_coef_addr,
  input  logic signed [COEF_WIDTH-1:0] iv_coef_data
);

  localparam int PROD_W    = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + TAP_W;
  localparam int HIST_N    = CHANNELS * FIR_DEPTH;
  localparam int HIST_AW   = CH_W + TAP_W;
  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WRITE, S_MAC, S_DRAIN, S_OUTPUT} state_t;

  state_t state, state_nxt;

  logic signed [COEF_WIDTH-1:0] coef_mem [FIR_DEPTH];
  logic signed [DATA_WIDTH-1:0] hist_mem [2**HIST_AW];
  logic        [TAP_W-1:0]      wr_ptr   [2**CH_W];

  logic [HIST_AW-1:0] clr_cnt;
  logic [TAP_W-1:0]   tap_cnt;
  logic               drain_cnt;
  logic               din_legal;
  logic               accept;
  logic               coef_we_ok;

  logic signed [DATA_WIDTH-1:0] smp_din;
  logic        [CH_W-1:0]       smp_ch;
  logic        [TAP_W-1:0]      base_ptr;
  logic        [HIST_AW-1:0]    rd_addr;

  logic signed [DATA_WIDTH-1:0] rd_p0;
  logic signed [COEF_WIDTH-1:0] coef_p0;
  logic                         vld_p0, first_p0, last_p0;
  logic signed [PROD_W-1:0]     prod_p1;
  logic                         vld_p1, first_p1, last_p1;
  logic signed [ACC_WIDTH-1:0]  acc_p2;
  logic                         vld_p2;

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;
`endif

  function automatic logic signed [DATA_WIDTH-1:0] reduce_out(input logic signed [ACC_WIDTH-1:0] acc);
`ifdef FIR_SATURATE_EN
    logic signed [ACC_WIDTH-1:0] sh;
    sh = acc >>> OUT_SHIFT;
    if (sh > OUT_MAX)      reduce_out = OUT_MAX[DATA_WIDTH-1:0];
    else if (sh < OUT_MIN) reduce_out = OUT_MIN[DATA_WIDTH-1:0];
    else                   reduce_out = sh[DATA_WIDTH-1:0];
`else
    reduce_out = DATA_WIDTH'(acc >>> OUT_SHIFT);
`endif
  endfunction

  assign o_din_ready = (state == S_IDLE);
  assign din_legal   = ({1'b0, iv_din_ch} < CH_LIMIT);
  assign accept      = (state == S_IDLE) && i_din_valid && din_legal;
  assign coef_we_ok  = i_coef_we && ((state == S_IDLE) || (state == S_CLEAR));
  assign rd_addr     = {smp_ch, base_ptr - tap_cnt};

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:  if (clr_cnt == HIST_AW'(HIST_N - 1)) state_nxt = S_IDLE;
      S_IDLE:   if (accept) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_MAC;
      S_MAC:    if (tap_cnt == TAP_W'(FIR_DEPTH - 1)) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_cnt) state_nxt = S_OUTPUT;
      S_OUTPUT: if (o_dout_valid && i_dout_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_CLEAR;
      clr_cnt      <= '0;
      tap_cnt      <= '0;
      drain_cnt    <= 1'b0;
      for (int i = 0; i < 2**CH_W; i++) wr_ptr[i] <= '0;
      vld_p0       <= 1'b0;
      first_p0     <= 1'b0;
      last_p0      <= 1'b0;
      vld_p1       <= 1'b0;
      first_p1     <= 1'b0;
      last_p1      <= 1'b0;
      vld_p2       <= 1'b0;
      o_dout_valid <= 1'b0;
      ov_dout      <= '0;
      ov_dout_ch   <= '0;
    end else if (i_en) begin
      state     <= state_nxt;
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      tap_cnt   <= (state == S_MAC) ? tap_cnt + TAP_W'(1) : '0;
      if (state == S_CLEAR) clr_cnt <= clr_cnt + HIST_AW'(1);
      if (state == S_WRITE) wr_ptr[smp_ch] <= wr_ptr[smp_ch] + TAP_W'(1);
      // p0: read issue -> history/coefficient registered
      vld_p0   <= (state == S_MAC);
      first_p0 <= (state == S_MAC) && (tap_cnt == '0);
      last_p0  <= (state == S_MAC) && (tap_cnt == TAP_W'(FIR_DEPTH - 1));
      // p1: product
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      // p2: accumulator holds the final sum when vld_p2 is set
      vld_p2   <= last_p1;
      // output register, held until the consumer takes it
      if (vld_p2) begin
        o_dout_valid <= 1'b1;
        ov_dout      <= reduce_out(acc_p2);
        ov_dout_ch   <= smp_ch;
      end else if (o_dout_valid && i_dout_ready) begin
        o_dout_valid <= 1'b0;
      end
    end
  end

  // Data storage and datapath carry no reset; history is wiped by the CLEAR sweep instead.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (accept) begin
        smp_din <= iv_din;
        smp_ch  <= iv_din_ch;
      end
      if (coef_we_ok) coef_mem[iv_coef_addr] <= iv_coef_data;
      if (state == S_CLEAR) begin
        hist_mem[clr_cnt] <= '0;
      end else if (state == S_WRITE) begin
        hist_mem[{smp_ch, wr_ptr[smp_ch]}] <= smp_din;
        base_ptr <= wr_ptr[smp_ch];
      end
      rd_p0   <= hist_mem[rd_addr];
      coef_p0 <= coef_mem[tap_cnt];
      prod_p1 <= PROD_W'(rd_p0) * PROD_W'(coef_p0);
      if (vld_p1) acc_p2 <= first_p1 ? ACC_WIDTH'(prod_p1) : acc_p2 + ACC_WIDTH'(prod_p1);
    end
  end

endmodule
